// File: rtl/connect6_pkg.sv
// Shared encodings for the connect6 board logic: cell values, scan directions, scanner states.
package connect6_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_BLOCK = 2'b11;

    localparam logic [1:0] DIR_H = 2'd0;  // col+
    localparam logic [1:0] DIR_V = 2'd1;  // row+
    localparam logic [1:0] DIR_D = 2'd2;  // row+, col+
    localparam logic [1:0] DIR_A = 2'd3;  // row+, col-

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EV   = 3'd2,
        ST_ADV  = 3'd3,
        ST_DONE = 3'd4
    } scan_state_e;

endpackage

// File: rtl/scan_addr_gen.sv
// Window address arithmetic: cell-k address of a window, and the next on-board window start.
module scan_addr_gen
    import connect6_pkg::*;
#(
    parameter int unsigned BOARD_N = 19,
    parameter int unsigned POS_W   = 5,
    parameter int unsigned WIN_LEN = 6,
    parameter int unsigned KW      = 3
) (
    input  logic [POS_W-1:0] i_row,
    input  logic [POS_W-1:0] i_col,
    input  logic [1:0]       i_dir,
    input  logic [KW-1:0]    i_k,
    output logic [POS_W-1:0] o_cell_row_c,
    output logic [POS_W-1:0] o_cell_col_c,
    input  logic [POS_W-1:0] i_cur_row,
    input  logic [POS_W-1:0] i_cur_col,
    input  logic [1:0]       i_cur_dir,
    output logic [POS_W-1:0] o_nxt_row_c,
    output logic [POS_W-1:0] o_nxt_col_c,
    output logic [1:0]       o_nxt_dir_c,
    output logic             o_last_c
);

    localparam logic [POS_W-1:0] LAST_P = POS_W'(BOARD_N - 1);
    localparam logic [POS_W-1:0] SPAN_P = POS_W'(BOARD_N - WIN_LEN);
    localparam logic [POS_W-1:0] WM1_P  = POS_W'(WIN_LEN - 1);
    localparam logic [POS_W-1:0] ONE_P  = POS_W'(1);

    // Bounds of the on-board start region for each direction.
    function automatic logic [POS_W-1:0] row_max(input logic [1:0] dir);
        return (dir == DIR_H) ? LAST_P : SPAN_P;
    endfunction

    function automatic logic [POS_W-1:0] col_min(input logic [1:0] dir);
        return (dir == DIR_A) ? WM1_P : '0;
    endfunction

    function automatic logic [POS_W-1:0] col_max(input logic [1:0] dir);
        return ((dir == DIR_V) || (dir == DIR_A)) ? LAST_P : SPAN_P;
    endfunction

    logic [POS_W-1:0] kp;

    always_comb begin
        kp           = POS_W'(i_k);
        o_cell_row_c = i_row;
        o_cell_col_c = i_col;
        case (i_dir)
            DIR_H: o_cell_col_c = i_col + kp;
            DIR_V: o_cell_row_c = i_row + kp;
            DIR_D: begin
                o_cell_row_c = i_row + kp;
                o_cell_col_c = i_col + kp;
            end
            default: begin
                o_cell_row_c = i_row + kp;
                o_cell_col_c = i_col - kp;
            end
        endcase
    end

    // Row-major within a direction, then on to the next direction.
    always_comb begin
        o_nxt_row_c = i_cur_row;
        o_nxt_col_c = i_cur_col;
        o_nxt_dir_c = i_cur_dir;
        o_last_c    = 1'b0;
        if (i_cur_col != col_max(i_cur_dir)) begin
            o_nxt_col_c = i_cur_col + ONE_P;
        end else if (i_cur_row != row_max(i_cur_dir)) begin
            o_nxt_row_c = i_cur_row + ONE_P;
            o_nxt_col_c = col_min(i_cur_dir);
        end else if (i_cur_dir != DIR_A) begin
            o_nxt_dir_c = i_cur_dir + 2'd1;
            o_nxt_row_c = '0;
            o_nxt_col_c = col_min(i_cur_dir + 2'd1);
        end else begin
            o_last_c = 1'b1;
        end
    end

endmodule

// File: rtl/line_scanner.sv
// Scans every WIN_LEN window of the shadow board in four directions for windows holding
// only the requested colour plus empties, and reports the empties of the first such window.
module line_scanner
    import connect6_pkg::*;
#(
    parameter  int unsigned BOARD_N = 19,
    parameter  int unsigned POS_W   = 5,
    parameter  int unsigned WIN_LEN = 6,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned KW      = $clog2(WIN_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_colour,
    input  logic [KW-1:0]    i_need,
    input  logic             i_mode,
    input  logic             i_abort,
    output logic [POS_W-1:0] o_sb_rd_row,
    output logic [POS_W-1:0] o_sb_rd_col,
    input  logic [1:0]       i_sb_rd_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic [POS_W-1:0] o_row1,
    output logic [POS_W-1:0] o_col1,
    output logic [POS_W-1:0] o_row2,
    output logic [POS_W-1:0] o_col2,
    output logic [KW-1:0]    o_empty_cnt,
    output logic [CNT_W-1:0] o_win_cnt
);

    localparam logic [KW-1:0]    K_LAST = KW'(WIN_LEN - 1);
    localparam logic [KW-1:0]    ONE_K  = KW'(1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    scan_state_e state_q, state_d;

    logic [1:0]       colour_q, colour_d;
    logic [KW-1:0]    need_q, need_d;
    logic             mode_q, mode_d;
    logic [POS_W-1:0] row_q, row_d, col_q, col_d;
    logic [1:0]       dir_q, dir_d;
    logic [KW-1:0]    k_q, k_d, own_q, own_d, emp_q, emp_d;
    logic             bad_q, bad_d;
    logic [POS_W-1:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
    logic [POS_W-1:0] s2_row_q, s2_row_d, s2_col_q, s2_col_d;
    logic [POS_W-1:0] addr_row_q, addr_row_d, addr_col_q, addr_col_d;
    logic             busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic [POS_W-1:0] row1_q, row1_d, col1_q, col1_d, row2_q, row2_d, col2_q, col2_d;
    logic [KW-1:0]    ecnt_q, ecnt_d;
    logic [CNT_W-1:0] win_q, win_d;

    logic [POS_W-1:0] cell_row_c, cell_col_c, nxt_row_c, nxt_col_c;
    logic [1:0]       nxt_dir_c;
    logic             last_c;
    logic             colour_ok_c, cell_own_c, cell_empty_c, cell_bad_c, qualify_c, clear_c;

    scan_addr_gen #(
        .BOARD_N (BOARD_N),
        .POS_W   (POS_W),
        .WIN_LEN (WIN_LEN),
        .KW      (KW)
    ) u_addr (
        .i_row        (row_d),
        .i_col        (col_d),
        .i_dir        (dir_d),
        .i_k          (k_d),
        .o_cell_row_c (cell_row_c),
        .o_cell_col_c (cell_col_c),
        .i_cur_row    (row_q),
        .i_cur_col    (col_q),
        .i_cur_dir    (dir_q),
        .o_nxt_row_c  (nxt_row_c),
        .o_nxt_col_c  (nxt_col_c),
        .o_nxt_dir_c  (nxt_dir_c),
        .o_last_c     (last_c)
    );

    assign colour_ok_c  = (i_colour == CELL_BLACK) || (i_colour == CELL_WHITE);
    assign cell_empty_c = (i_sb_rd_data == CELL_EMPTY);
    assign cell_own_c   = (i_sb_rd_data == colour_q);
    assign cell_bad_c   = !cell_empty_c && !cell_own_c;
    assign qualify_c    = !bad_q && (own_q >= need_q);
    assign clear_c      = ((state_q == ST_IDLE) && i_start) || i_abort;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = colour_ok_c ? ST_RD : ST_DONE;
            ST_RD:   state_d = ST_EV;
            ST_EV:   state_d = (cell_bad_c || (k_q == K_LAST)) ? ST_ADV : ST_RD;
            ST_ADV:  state_d = ((qualify_c && !mode_q) || last_c) ? ST_DONE : ST_RD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (i_abort) state_d = ST_IDLE;
    end

    always_comb begin
        colour_d = colour_q;
        need_d   = need_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        dir_d    = dir_q;
        k_d      = k_q;
        own_d    = own_q;
        emp_d    = emp_q;
        bad_d    = bad_q;
        s1_row_d = s1_row_q;
        s1_col_d = s1_col_q;
        s2_row_d = s2_row_q;
        s2_col_d = s2_col_q;
        found_d  = found_q;
        row1_d   = row1_q;
        col1_d   = col1_q;
        row2_d   = row2_q;
        col2_d   = col2_q;
        ecnt_d   = ecnt_q;
        win_d    = win_q;
        case (state_q)
            ST_IDLE: if (i_start) begin
                colour_d = i_colour;
                need_d   = i_need;
                mode_d   = i_mode;
            end
            ST_EV: begin
                k_d = k_q + ONE_K;
                if (cell_bad_c) begin
                    bad_d = 1'b1;
                end else if (cell_own_c) begin
                    own_d = own_q + ONE_K;
                end else begin
                    emp_d = emp_q + ONE_K;
                    if (emp_q == '0) begin
                        s1_row_d = addr_row_q;
                        s1_col_d = addr_col_q;
                    end else if (emp_q == ONE_K) begin
                        s2_row_d = addr_row_q;
                        s2_col_d = addr_col_q;
                    end
                end
            end
            ST_ADV: begin
                if (qualify_c) begin
                    if (win_q != '1) win_d = win_q + ONE_C;
                    if (!found_q) begin
                        found_d = 1'b1;
                        row1_d  = s1_row_q;
                        col1_d  = s1_col_q;
                        row2_d  = s2_row_q;
                        col2_d  = s2_col_q;
                        ecnt_d  = emp_q;
                    end
                end
                row_d    = nxt_row_c;
                col_d    = nxt_col_c;
                dir_d    = nxt_dir_c;
                k_d      = '0;
                own_d    = '0;
                emp_d    = '0;
                bad_d    = 1'b0;
                s1_row_d = '0;
                s1_col_d = '0;
                s2_row_d = '0;
                s2_col_d = '0;
            end
            default: ;
        endcase
        // Fresh scan or abandoned scan: wipe results and rewind to the first window.
        if (clear_c) begin
            row_d    = '0;
            col_d    = '0;
            dir_d    = DIR_H;
            k_d      = '0;
            own_d    = '0;
            emp_d    = '0;
            bad_d    = 1'b0;
            s1_row_d = '0;
            s1_col_d = '0;
            s2_row_d = '0;
            s2_col_d = '0;
            found_d  = 1'b0;
            row1_d   = '0;
            col1_d   = '0;
            row2_d   = '0;
            col2_d   = '0;
            ecnt_d   = '0;
            win_d    = '0;
        end
        busy_d = (state_d == ST_RD) || (state_d == ST_EV) || (state_d == ST_ADV);
        done_d = (state_d == ST_DONE);
    end

    // Read address is registered, so it is computed from the window the FSM is about to read.
    always_comb begin
        addr_row_d = addr_row_q;
        addr_col_d = addr_col_q;
        if (state_d == ST_RD) begin
            addr_row_d = cell_row_c;
            addr_col_d = cell_col_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            colour_q   <= CELL_EMPTY;
            need_q     <= '0;
            mode_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            dir_q      <= DIR_H;
            k_q        <= '0;
            own_q      <= '0;
            emp_q      <= '0;
            bad_q      <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s2_row_q   <= '0;
            s2_col_q   <= '0;
            addr_row_q <= '0;
            addr_col_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            row1_q     <= '0;
            col1_q     <= '0;
            row2_q     <= '0;
            col2_q     <= '0;
            ecnt_q     <= '0;
            win_q      <= '0;
        end else begin
            colour_q   <= colour_d;
            need_q     <= need_d;
            mode_q     <= mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dir_q      <= dir_d;
            k_q        <= k_d;
            own_q      <= own_d;
            emp_q      <= emp_d;
            bad_q      <= bad_d;
            s1_row_q   <= s1_row_d;
            s1_col_q   <= s1_col_d;
            s2_row_q   <= s2_row_d;
            s2_col_q   <= s2_col_d;
            addr_row_q <= addr_row_d;
            addr_col_q <= addr_col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            row1_q     <= row1_d;
            col1_q     <= col1_d;
            row2_q     <= row2_d;
            col2_q     <= col2_d;
            ecnt_q     <= ecnt_d;
            win_q      <= win_d;
        end
    end

    assign o_sb_rd_row = addr_row_q;
    assign o_sb_rd_col = addr_col_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_found     = found_q;
    assign o_row1      = row1_q;
    assign o_col1      = col1_q;
    assign o_row2      = row2_q;
    assign o_col2      = col2_q;
    assign o_empty_cnt = ecnt_q;
    assign o_win_cnt   = win_q;

endmodule

// File: tb/tb_line_scanner.sv
// Directed bench for line_scanner: a behavioural shadow board with one-cycle read latency,
// hand-computed results and start-to-done cycle counts.
module tb_line_scanner;
    import connect6_pkg::*;

    localparam int unsigned BOARD_N   = 19;
    localparam int unsigned POS_W     = 5;
    localparam int unsigned WIN_LEN   = 6;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned KW        = $clog2(WIN_LEN + 1);
    localparam int unsigned FULL_SCAN = 924 * 13 + 1;
    localparam int unsigned BOUND     = 20000;

    logic             i_clk    = 1'b0;
    logic             i_rst    = 1'b0;
    logic             i_start  = 1'b0;
    logic [1:0]       i_colour = 2'b00;
    logic [KW-1:0]    i_need   = '0;
    logic             i_mode   = 1'b0;
    logic             i_abort  = 1'b0;
    logic [1:0]       i_sb_rd_data = 2'b00;
    logic [POS_W-1:0] o_sb_rd_row, o_sb_rd_col;
    logic             o_busy, o_done, o_found;
    logic [POS_W-1:0] o_row1, o_col1, o_row2, o_col2;
    logic [KW-1:0]    o_empty_cnt;
    logic [CNT_W-1:0] o_win_cnt;

    logic [1:0] board [BOARD_N][BOARD_N];
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    logic       busy_seen;
    logic       done_seen;

    line_scanner #(
        .BOARD_N (BOARD_N),
        .POS_W   (POS_W),
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_colour     (i_colour),
        .i_need       (i_need),
        .i_mode       (i_mode),
        .i_abort      (i_abort),
        .o_sb_rd_row  (o_sb_rd_row),
        .o_sb_rd_col  (o_sb_rd_col),
        .i_sb_rd_data (i_sb_rd_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_found      (o_found),
        .o_row1       (o_row1),
        .o_col1       (o_col1),
        .o_row2       (o_row2),
        .o_col2       (o_col2),
        .o_empty_cnt  (o_empty_cnt),
        .o_win_cnt    (o_win_cnt)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (int'(o_sb_rd_row) < BOARD_N && int'(o_sb_rd_col) < BOARD_N)
            i_sb_rd_data <= board[o_sb_rd_row][o_sb_rd_col];
        else
            i_sb_rd_data <= CELL_BLOCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pos4(input logic [POS_W-1:0] r1, input logic [POS_W-1:0] c1,
                                         input logic [POS_W-1:0] r2, input logic [POS_W-1:0] c2);
        return {12'b0, r1, c1, r2, c2};
    endfunction

    task automatic clear_board();
        for (int r = 0; r < BOARD_N; r++)
            for (int c = 0; c < BOARD_N; c++)
                board[r][c] = CELL_EMPTY;
    endtask

    task automatic start_scan(input logic [1:0] colour, input logic [KW-1:0] need, input logic mode);
        repeat (2) @(negedge i_clk);
        i_colour = colour;
        i_need   = need;
        i_mode   = mode;
        i_start  = 1'b1;
        @(posedge i_clk);
        #1;
        i_start   = 1'b0;
        busy_seen = o_busy;
    endtask

    // n is the cycle index of o_done, the start-accept cycle being index 0.
    task automatic wait_done(output int n);
        n = 1;
        while (o_done !== 1'b1 && n < int'(BOUND)) begin
            @(posedge i_clk);
            #1;
            n++;
        end
    endtask

    initial begin
        clear_board();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_found", 32'(o_found), 32'd0);
        chk("rst_win",   32'(o_win_cnt), 32'd0);
        chk("rst_pos",   pos4(o_row1, o_col1, o_row2, o_col2), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // empty board, exhaustive: nothing qualifies, every window read in full
        start_scan(CELL_BLACK, KW'(1), 1'b1);
        chk("empty_busy", 32'(busy_seen), 32'd1);
        wait_done(cyc);
        chk("empty_cycles", 32'(cyc), 32'(FULL_SCAN));
        chk("empty_found",  32'(o_found), 32'd0);
        chk("empty_win",    32'(o_win_cnt), 32'd0);
        chk("empty_busy_done", 32'(o_busy), 32'd0);

        // need 0 stops on the very first window
        start_scan(CELL_WHITE, KW'(0), 1'b0);
        wait_done(cyc);
        chk("need0_cycles", 32'(cyc), 32'd14);
        chk("need0_found",  32'(o_found), 32'd1);
        chk("need0_win",    32'(o_win_cnt), 32'd1);
        chk("need0_pos",    pos4(o_row1, o_col1, o_row2, o_col2), pos4(5'd0, 5'd0, 5'd0, 5'd1));
        chk("need0_ecnt",   32'(o_empty_cnt), 32'd6);

        // four blacks in row 3 with a gap: first match dir0 start (3,3)
        board[3][4] = CELL_BLACK;
        board[3][5] = CELL_BLACK;
        board[3][6] = CELL_BLACK;
        board[3][8] = CELL_BLACK;
        start_scan(CELL_BLACK, KW'(4), 1'b0);
        wait_done(cyc);
        chk("row_cycles", 32'(cyc), 32'(46 * 13 + 1));
        chk("row_found",  32'(o_found), 32'd1);
        chk("row_win",    32'(o_win_cnt), 32'd1);
        chk("row_pos",    pos4(o_row1, o_col1, o_row2, o_col2), pos4(5'd3, 5'd3, 5'd3, 5'd7));
        chk("row_ecnt",   32'(o_empty_cnt), 32'd2);

        // white in the gap kills every candidate; windows hitting it stop early
        board[3][7] = CELL_WHITE;
        start_scan(CELL_BLACK, KW'(4), 1'b1);
        wait_done(cyc);
        chk("blk_cycles", 32'(cyc), 32'(FULL_SCAN - 114));
        chk("blk_found",  32'(o_found), 32'd0);
        chk("blk_win",    32'(o_win_cnt), 32'd0);

        // five on the main diagonal: two qualifying diagonal windows
        clear_board();
        for (int i = 5; i <= 9; i++) board[i][i] = CELL_BLACK;
        start_scan(CELL_BLACK, KW'(5), 1'b1);
        wait_done(cyc);
        chk("diag_cycles", 32'(cyc), 32'(FULL_SCAN));
        chk("diag_found",  32'(o_found), 32'd1);
        chk("diag_win",    32'(o_win_cnt), 32'd2);
        chk("diag_pos",    pos4(o_row1, o_col1, o_row2, o_col2), pos4(5'd4, 5'd4, 5'd0, 5'd0));
        chk("diag_ecnt",   32'(o_empty_cnt), 32'd1);

        // invalid colour: immediate done, previous results cleared
        start_scan(CELL_BLOCK, KW'(1), 1'b1);
        chk("bad_colour_busy", 32'(busy_seen), 32'd0);
        wait_done(cyc);
        chk("bad_colour_cycles", 32'(cyc), 32'd1);
        chk("bad_colour_found",  32'(o_found), 32'd0);

        // abort mid-scan: busy drops next cycle, no done pulse follows
        start_scan(CELL_BLACK, KW'(5), 1'b1);
        repeat (50) @(posedge i_clk);
        @(negedge i_clk);
        i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        i_abort = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        done_seen = o_done;
        repeat (30) begin
            @(posedge i_clk);
            #1;
            if (o_done) done_seen = 1'b1;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_win",     32'(o_win_cnt), 32'd0);

        // async reset mid-scan, then an uninterrupted rerun
        start_scan(CELL_BLACK, KW'(5), 1'b1);
        repeat (300) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_addr", 32'({o_sb_rd_row, o_sb_rd_col}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        start_scan(CELL_BLACK, KW'(5), 1'b1);
        wait_done(cyc);
        chk("rerun_cycles", 32'(cyc), 32'(FULL_SCAN));
        chk("rerun_win",    32'(o_win_cnt), 32'd2);
        chk("rerun_pos",    pos4(o_row1, o_col1, o_row2, o_col2), pos4(5'd4, 5'd4, 5'd0, 5'd0));
        chk("rerun_ecnt",   32'(o_empty_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
